pcle_dn: RTL and testbench

Registered 8-bit loadable down-counter stage with a cascadable borrow chain and a one-shot/auto-reload timer FSM. It is the count-down counterpart of the combinational up-count cell in the lgsynth91 counter benchmarks: it decrements instead of incrementing and produces borrow instead of carry. The same parallel-load, enable, hold and lookahead-carry style is kept, but the state is held internally. Stages chain LSB→MSB through `bin`/`bout` to build wider timers.

---
 rtl/pcle_pkg.sv | 14 +
 rtl/pcle_dn_borrow.sv | 22 ++
 rtl/pcle_dn.sv | 81 ++++++++
 tb/tb_pcle_dn.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pcle_pkg.sv
// Shared definitions for the pcle_dn down-counter stage.
package pcle_pkg;

    // Default stage width
    localparam int PCLE_W = 8;

    // Timer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pcle_dn_state_t;

endpackage

// File: rtl/pcle_dn_borrow.sv
// Zero-detect and borrow lookahead for one pcle_dn stage; the count-down
// counterpart of the up-count carry cell.
module pcle_dn_borrow #(
    parameter int W = 8
) (
    input  logic [W-1:0] cnt,
    input  logic         cq,
    input  logic         run,
    output logic         bout,
    output logic [W-1:0] cnt_dec
);

    logic zero;

    // Borrow only when a qualified count hits zero while running
    always_comb begin
        zero    = (cnt == '0);
        bout    = cq & zero & run;
        cnt_dec = cnt - W'(1);
    end

endmodule

// File: rtl/pcle_dn.sv
// Registered loadable down-counter stage with cascadable borrow chain and
// one-shot timer FSM. Define PCLE_DN_AUTORELOAD_EN to reload from rld on
// each borrow instead of stopping in DONE.
module pcle_dn
    import pcle_pkg::*;
#(
    parameter int W = PCLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         hold,
    input  logic         bin,
    output logic [W-1:0] cnt,
    output logic         bout,
    output logic         expire,
    output logic         busy
);

    pcle_dn_state_t state;
    logic [W-1:0]   cnt_q;
    logic [W-1:0]   rld;
    logic [W-1:0]   cnt_dec;
    logic           expire_q;
    logic           cq;
    logic           run;

    // Qualified count: load pre-empts, hold overrides enable, bin gates the stage
    always_comb begin
        cq  = ~load & en & ~hold & bin;
        run = (state == RUN);
    end

    pcle_dn_borrow #(
        .W (W)
    ) u_borrow (
        .cnt     (cnt_q),
        .cq      (cq),
        .run     (run),
        .bout    (bout),
        .cnt_dec (cnt_dec)
    );

    // Counter, reload register, FSM and expire pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= '0;
            rld      <= '0;
            expire_q <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (load) begin
                state <= RUN;
                cnt_q <= load_val;
                rld   <= load_val;
            end else if (run && cq) begin
                if (bout) begin
                    expire_q <= 1'b1;
`ifdef PCLE_DN_AUTORELOAD_EN
                    cnt_q <= rld;
`else
                    state <= DONE;
`endif
                end else begin
                    cnt_q <= cnt_dec;
                end
            end
        end
    end

    // Registered outputs
    always_comb begin
        cnt    = cnt_q;
        expire = expire_q;
        busy   = run;
    end

endmodule

// File: tb/tb_pcle_dn.sv
// Self-checking bench for pcle_dn: scoreboard of registered outputs plus
// directed checks and a two-stage cascade.
module tb_pcle_dn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, en, hold, bin;
    logic [7:0] load_val;
    logic [7:0] cnt;
    logic       bout, expire, busy;

    // Cascade pair
    logic       c_load, c_en;
    logic [7:0] lo_cnt, hi_cnt;
    logic       lo_bout, hi_bout, lo_exp, hi_exp, lo_busy, hi_busy;

    always #5 clk = ~clk;

    pcle_dn #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .en(en), .hold(hold), .bin(bin), .cnt(cnt), .bout(bout),
        .expire(expire), .busy(busy)
    );

    pcle_dn #(.W(8)) u_lo (
        .clk(clk), .rst_n(rst_n), .load(c_load), .load_val(8'h01),
        .en(c_en), .hold(1'b0), .bin(1'b1), .cnt(lo_cnt), .bout(lo_bout),
        .expire(lo_exp), .busy(lo_busy)
    );

    pcle_dn #(.W(8)) u_hi (
        .clk(clk), .rst_n(rst_n), .load(c_load), .load_val(8'h00),
        .en(c_en), .hold(1'b0), .bin(lo_bout), .cnt(hi_cnt), .bout(hi_bout),
        .expire(hi_exp), .busy(hi_busy)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       expire;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: 0 = idle, 1 = run, 2 = done
    int         m_st  = 0;
    logic [7:0] m_cnt = 8'h00;
    logic [7:0] m_rld = 8'h00;
    logic       m_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_cnt = 8'h00;
        m_rld = 8'h00;
        m_exp = 1'b0;
        sb.delete();
    endtask

    task automatic pop_check();
        exp_t x;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            chk("cnt", {24'd0, cnt}, {24'd0, x.cnt});
            chk("expire", {31'd0, expire}, {31'd0, x.expire});
            chk("busy", {31'd0, busy}, {31'd0, x.busy});
        end
    endtask

    // One clock of stimulus: check combinational bout, advance model, push, pop
    task automatic step(input logic ld, input logic [7:0] lv,
                        input logic e, input logic h, input logic b);
        logic cq;
        exp_t x;
        @(negedge clk);
        load = ld; load_val = lv; en = e; hold = h; bin = b;
        #1;
        cq = !ld && e && !h && b;
        chk("bout", {31'd0, bout}, {31'd0, (cq && m_st == 1 && m_cnt == 8'h00)});
        m_exp = 1'b0;
        if (ld) begin
            m_st  = 1;
            m_cnt = lv;
            m_rld = lv;
        end else if (m_st == 1 && cq) begin
            if (m_cnt == 8'h00) begin
                m_exp = 1'b1;
`ifdef PCLE_DN_AUTORELOAD_EN
                m_cnt = m_rld;
`else
                m_st = 2;
`endif
            end else begin
                m_cnt = m_cnt - 8'h01;
            end
        end
        x.cnt = m_cnt; x.expire = m_exp; x.busy = (m_st == 1);
        sb.push_back(x);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; hold = 1'b0; bin = 1'b1;
        c_load = 1'b0; c_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", {24'd0, cnt}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_expire", {31'd0, expire}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Reset mid-count
        step(1'b1, 8'h37, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_cnt", {24'd0, cnt}, 32'h37);
        load = 1'b0; en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_cnt", {24'd0, cnt}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        chk("midrst_expire", {31'd0, expire}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("idle_cnt", {24'd0, cnt}, 32'h0);

        // Load 3 then count down through the borrow
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        chk("ld3_cnt", {24'd0, cnt}, 32'h03);
        for (int i = 2; i >= 0; i--) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("dec_cnt", {24'd0, cnt}, i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("brw_expire", {31'd0, expire}, 32'h1);
`ifdef PCLE_DN_AUTORELOAD_EN
        chk("ar_cnt", {24'd0, cnt}, 32'h03);
        chk("ar_busy", {31'd0, busy}, 32'h1);
`else
        chk("os_cnt", {24'd0, cnt}, 32'h00);
        chk("os_busy", {31'd0, busy}, 32'h0);
`endif
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Reload period of three with load_val 2
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Load at zero with a pending borrow: load wins
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        chk("ldwin_cnt", {24'd0, cnt}, 32'hA5);
        chk("ldwin_expire", {31'd0, expire}, 32'h0);
        chk("ldwin_busy", {31'd0, busy}, 32'h1);

        // Zero load borrows on the first qualified count
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("zld_expire", {31'd0, expire}, 32'h1);

        // Hold and bin freeze
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("hold_cnt", {24'd0, cnt}, 32'h10);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("bin0_cnt", {24'd0, cnt}, 32'h10);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("resume_cnt", {24'd0, cnt}, 32'h0D);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) != 0));
        end

        // Two-stage cascade
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        c_load = 1'b1; c_en = 1'b0;
        @(posedge clk);
        #1;
        chk("cas_ld", {16'd0, hi_cnt, lo_cnt}, 32'h0001);
        chk("cas_busy", {30'd0, hi_busy, lo_busy}, 32'h3);
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        #1;
        chk("cas_bout0", {30'd0, hi_bout, lo_bout}, 32'h0);
        @(posedge clk);
        #1;
        chk("cas_zero", {16'd0, hi_cnt, lo_cnt}, 32'h0000);
        chk("cas_bout1", {30'd0, hi_bout, lo_bout}, 32'h3);
        @(posedge clk);
        #1;
        chk("cas_expire", {30'd0, hi_exp, lo_exp}, 32'h3);
        @(negedge clk) c_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
